// File: rtl/noc_link_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_link_tx_if
// Description : Signal bundle between the local switch output port, the link
//               transmitter and the backward link path. Carries the local
//               push handshake (FLIT_in/VALID_in/FWDAUX1_in/READY_out), the
//               forward link (FLIT_out/VALID_out/FWDAUX1_out) and the backward
//               auxiliary signals (BWDAUX1..3_in).
//               slave  : the transmitter's view.
//               master : the environment's view (switch + backward link).
// Revision    : 1.0 - initial release
// ============================================================================
interface noc_link_tx_if #(
    parameter int FLIT_WIDTH = 32
) ();
    logic [FLIT_WIDTH-1:0] FLIT_in;
    logic                  VALID_in;
    logic                  FWDAUX1_in;
    logic                  READY_out;
    logic [FLIT_WIDTH-1:0] FLIT_out;
    logic                  VALID_out;
    logic                  FWDAUX1_out;
    logic                  BWDAUX1_in;
    logic                  BWDAUX2_in;
    logic                  BWDAUX3_in;

    modport slave (
        input  FLIT_in, VALID_in, FWDAUX1_in,
        output READY_out,
        output FLIT_out, VALID_out, FWDAUX1_out,
        input  BWDAUX1_in, BWDAUX2_in, BWDAUX3_in
    );

    modport master (
        output FLIT_in, VALID_in, FWDAUX1_in,
        input  READY_out,
        input  FLIT_out, VALID_out, FWDAUX1_out,
        output BWDAUX1_in, BWDAUX2_in, BWDAUX3_in
    );
endinterface
`default_nettype wire

// File: rtl/noc_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : noc_link_tx
// Description : Transmitter end of a NoC switch-to-switch link. Buffers flits
//               from the local output port in a small circular FIFO and
//               launches them onto the forward link under credit-based flow
//               control, tracking wormhole packet boundaries.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               link (slave)  - push handshake, forward link, backward aux
//               credit_count  - credits currently available
//               in_packet     - a packet has started but its tail is unsent
//               credit_err    - sticky credit-overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module noc_link_tx #(
    parameter int FLIT_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    noc_link_tx_if.slave              link,
    output logic [CNT_WIDTH-1:0]      credit_count,
    output logic                      in_packet,
    output logic                      credit_err
);
    localparam int                   PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_FIFO_FULL  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_CREDIT_MAX = CNT_WIDTH'(CREDITS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    // Each entry stores {tail, flit}.
    logic [FLIT_WIDTH:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [CNT_WIDTH-1:0]    r_credit;
    logic                    r_credit_err;
    logic [FLIT_WIDTH-1:0]   r_flit_out;
    logic                    r_valid_out;
    logic                    r_tail_out;
    state_t                  r_state;
    state_t                  w_state_next;

    logic                    w_ready;
    logic                    w_push;
    logic                    w_launch;
    logic [FLIT_WIDTH:0]     w_head;
    logic                    w_head_tail;
    logic                    w_unused_aux3;

    // BWDAUX3 is reserved on this link.
    assign w_unused_aux3 = link.BWDAUX3_in;

    // Ready looks only at registered occupancy, so a pop in the same cycle
    // never opens an extra slot combinationally.
    assign w_ready     = (r_count < c_FIFO_FULL) && !rst;
    assign w_push      = link.VALID_in && w_ready;
    // A credit returning this cycle is not counted yet: launch needs a
    // credit already held in the register.
    assign w_launch    = (r_count != '0) && (r_credit != '0) && !link.BWDAUX2_in;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_tail = w_head[FLIT_WIDTH];

    // Storage has no reset: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {link.FWDAUX1_in, link.FLIT_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_credit     <= c_CREDIT_MAX;
            r_credit_err <= 1'b0;
            r_flit_out   <= '0;
            r_tail_out   <= 1'b0;
            r_valid_out  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_launch) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_launch})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase

            // Flit/tail hold their last value when nothing launches.
            r_valid_out <= w_launch;
            if (w_launch) begin
                r_flit_out <= w_head[FLIT_WIDTH-1:0];
                r_tail_out <= w_head_tail;
            end

            case ({link.BWDAUX1_in, w_launch})
                2'b10: begin
                    if (r_credit == c_CREDIT_MAX) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credit <= r_credit + CNT_WIDTH'(1);
                    end
                end
                2'b01:   r_credit <= r_credit - CNT_WIDTH'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    // Packet tracking: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Packet tracking: moves only when a flit launches.
    always_comb begin
        w_state_next = r_state;
        if (w_launch) begin
            case (r_state)
                S_IDLE:  w_state_next = w_head_tail ? S_IDLE : S_BODY;
                S_BODY:  w_state_next = w_head_tail ? S_IDLE : S_BODY;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign link.READY_out   = w_ready;
    assign link.FLIT_out    = r_flit_out;
    assign link.VALID_out   = r_valid_out;
    assign link.FWDAUX1_out = r_tail_out;
    assign credit_count     = r_credit;
    assign in_packet        = (r_state == S_BODY);
    assign credit_err       = r_credit_err;
endmodule
`default_nettype wire

// File: tb/tb_noc_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_link_tx
// Description : Self-checking bench for noc_link_tx. A queue/integer model of
//               the transmitter predicts every output each cycle; a vector
//               table and hand-written sequences cover the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_link_tx;
    localparam int FW    = 32;
    localparam int DEPTH = 4;
    localparam int CRED  = 4;

    logic       clk;
    logic       rst;
    logic [2:0] credit_count;
    logic       in_packet;
    logic       credit_err;

    noc_link_tx_if #(.FLIT_WIDTH(FW)) ifc ();

    noc_link_tx #(
        .FLIT_WIDTH (FW),
        .FIFO_DEPTH (DEPTH),
        .CREDITS    (CRED),
        .CNT_WIDTH  (3)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .link         (ifc),
        .credit_count (credit_count),
        .in_packet    (in_packet),
        .credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state.
    logic [FW:0]   mq[$];
    int            m_credit;
    logic          m_valid;
    logic [FW-1:0] m_flit;
    logic          m_tail;
    logic          m_pkt;
    logic          m_err;
    logic          g_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check ready, advance the
    // model across the rising edge, compare every output at the next fall.
    task automatic cycle(input logic r, input logic vin, input logic [FW-1:0] f,
                         input logic t, input logic b1, input logic b2);
        logic exp_ready;
        logic launch;
        logic push;
        logic [FW:0] head;
        rst            = r;
        ifc.VALID_in   = vin;
        ifc.FLIT_in    = f;
        ifc.FWDAUX1_in = t;
        ifc.BWDAUX1_in = b1;
        ifc.BWDAUX2_in = b2;
        ifc.BWDAUX3_in = $urandom_range(0, 1);
        #1;
        exp_ready = !r && (mq.size() < DEPTH);
        g_ready   = ifc.READY_out;
        chk("ready", {31'b0, ifc.READY_out}, {31'b0, exp_ready});
        push   = vin && exp_ready;
        launch = (mq.size() > 0) && (m_credit > 0) && !b2;
        if (r) begin
            mq.delete();
            m_credit = CRED;
            m_valid  = 1'b0;
            m_flit   = '0;
            m_tail   = 1'b0;
            m_pkt    = 1'b0;
            m_err    = 1'b0;
        end else begin
            m_valid = launch;
            if (launch) begin
                head   = mq.pop_front();
                m_flit = head[FW-1:0];
                m_tail = head[FW];
                // After a launch the packet is open exactly when it was not a tail.
                m_pkt  = !head[FW];
            end
            if (push) mq.push_back({t, f});
            m_credit = m_credit + int'(b1) - int'(launch);
            if (m_credit > CRED) begin
                m_credit = CRED;
                m_err    = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("valid",  {31'b0, ifc.VALID_out},   {31'b0, m_valid});
        chk("flit",   ifc.FLIT_out,             m_flit);
        chk("tail",   {31'b0, ifc.FWDAUX1_out}, {31'b0, m_tail});
        chk("credit", {29'b0, credit_count},    m_credit);
        chk("in_pkt", {31'b0, in_packet},       {31'b0, m_pkt});
        chk("c_err",  {31'b0, credit_err},      {31'b0, m_err});
    endtask

    typedef struct {
        logic          r, vin;
        logic [FW-1:0] f;
        logic          t, b1, b2;
        logic          e_ready, e_valid;
        logic [FW-1:0] e_flit;
        logic          e_tail;
        int            e_credit;
        logic          e_pkt, e_err;
    } vec_t;

    vec_t vt[12];
    int   nv;
    int   seen;
    logic [FW-1:0] got[$];

    initial begin
        rst = 1'b1;
        ifc.VALID_in = 0; ifc.FLIT_in = '0; ifc.FWDAUX1_in = 0;
        ifc.BWDAUX1_in = 0; ifc.BWDAUX2_in = 0; ifc.BWDAUX3_in = 0;
        mq.delete();
        m_credit = CRED; m_valid = 0; m_flit = '0; m_tail = 0; m_pkt = 0; m_err = 0;
        @(negedge clk);

        // Vector table: r vin flit tail b1 b2 | ready valid flit tail credit pkt err
        vt[0]  = '{1, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,  0, 4, 0, 0};
        vt[1]  = '{0, 1, 32'hA,  1, 0, 0, 1, 0, 32'h0,  0, 4, 0, 0};
        vt[2]  = '{0, 0, 32'h0,  0, 0, 0, 1, 1, 32'hA,  1, 3, 0, 0};
        vt[3]  = '{0, 0, 32'h0,  0, 0, 0, 1, 0, 32'hA,  1, 3, 0, 0};
        vt[4]  = '{0, 0, 32'h0,  0, 1, 0, 1, 0, 32'hA,  1, 4, 0, 0};
        vt[5]  = '{0, 0, 32'h0,  0, 1, 0, 1, 0, 32'hA,  1, 4, 0, 1};
        vt[6]  = '{0, 0, 32'h0,  0, 0, 0, 1, 0, 32'hA,  1, 4, 0, 1};
        vt[7]  = '{1, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,  0, 4, 0, 0};
        vt[8]  = '{0, 1, 32'h11, 0, 0, 0, 1, 0, 32'h0,  0, 4, 0, 0};
        vt[9]  = '{0, 1, 32'h22, 0, 1, 0, 1, 1, 32'h11, 0, 4, 1, 0};
        vt[10] = '{0, 1, 32'h33, 1, 1, 0, 1, 1, 32'h22, 0, 4, 1, 0};
        vt[11] = '{0, 0, 32'h0,  0, 1, 0, 1, 1, 32'h33, 1, 4, 0, 0};
        nv = 12;
        for (int i = 0; i < nv; i++) begin
            cycle(vt[i].r, vt[i].vin, vt[i].f, vt[i].t, vt[i].b1, vt[i].b2);
            chk($sformatf("tbl%0d_ready", i),  {31'b0, g_ready},       {31'b0, vt[i].e_ready});
            chk($sformatf("tbl%0d_valid", i),  {31'b0, ifc.VALID_out}, {31'b0, vt[i].e_valid});
            chk($sformatf("tbl%0d_flit", i),   ifc.FLIT_out,           vt[i].e_flit);
            chk($sformatf("tbl%0d_tail", i),   {31'b0, ifc.FWDAUX1_out}, {31'b0, vt[i].e_tail});
            chk($sformatf("tbl%0d_credit", i), {29'b0, credit_count},  vt[i].e_credit);
            chk($sformatf("tbl%0d_pkt", i),    {31'b0, in_packet},     {31'b0, vt[i].e_pkt});
            chk($sformatf("tbl%0d_err", i),    {31'b0, credit_err},    {31'b0, vt[i].e_err});
        end

        // Credit exhaustion: six pushes, only four launch.
        cycle(1, 0, 0, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(0, i < 6, 32'h100 + i, 1, 0, 0);
            if (ifc.VALID_out) seen++;
        end
        chk("exhaust_launches", seen, 4);
        chk("exhaust_credit", {29'b0, credit_count}, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("ret_same_cycle_valid", {31'b0, ifc.VALID_out}, 0);
        chk("ret_credit", {29'b0, credit_count}, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("ret_valid", {31'b0, ifc.VALID_out}, 1);
        chk("ret_flit", ifc.FLIT_out, 32'h104);

        // Receiver hold: fill the buffer, then release.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'h200 + i, i == 3, 0, 1);
        cycle(0, 1, 32'h2FF, 0, 0, 1);
        chk("hold_full_ready", {31'b0, g_ready}, 0);
        chk("hold_credit", {29'b0, credit_count}, 4);
        got.delete();
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            if (ifc.VALID_out) got.push_back(ifc.FLIT_out);
        end
        chk("hold_launches", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk($sformatf("hold_order%0d", i), got[i], 32'h200 + i);
        end

        // Reset mid-packet with flits buffered.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h300, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("mid_pkt_open", {31'b0, in_packet}, 1);
        cycle(0, 1, 32'hDEAD0001, 0, 0, 1);
        cycle(0, 1, 32'hDEAD0002, 1, 0, 1);
        cycle(1, 0, 0, 0, 0, 0);
        chk("rst_valid", {31'b0, ifc.VALID_out}, 0);
        chk("rst_pkt", {31'b0, in_packet}, 0);
        chk("rst_credit", {29'b0, credit_count}, 4);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            if (i == 0) chk("rst_ready_after", {31'b0, g_ready}, 1);
            if (ifc.VALID_out) seen++;
        end
        chk("rst_no_old_flits", seen, 0);

        // Randomized traffic against the model.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
